// File: rtl/ghash_hkey_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : ghash_hkey_bank_if
// Description : Load / read / zeroize bundle between a GHASH subkey bank and
//               its requester (H-generation logic and GHASH datapath).
// Revision    : 1.0 - initial release
// ============================================================================
interface ghash_hkey_bank_if #(
    parameter int WIDTH    = 128,
    parameter int NUM_KEYS = 4,
    parameter int IDX_W    = 2
);
    logic                ld_valid;
    logic                ld_ready;
    logic [IDX_W-1:0]    ld_idx;
    logic [WIDTH-1:0]    ld_data;
    logic                rd_en;
    logic [IDX_W-1:0]    rd_idx;
    logic [WIDTH-1:0]    rd_data;
    logic                rd_valid;
    logic                rd_err;
    logic                zeroize;
    logic                busy;
    logic [NUM_KEYS-1:0] key_valid;

    // Requester side
    modport master (
        output ld_valid, ld_idx, ld_data, rd_en, rd_idx, zeroize,
        input  ld_ready, rd_data, rd_valid, rd_err, busy, key_valid
    );

    // Key bank side
    modport slave (
        input  ld_valid, ld_idx, ld_data, rd_en, rd_idx, zeroize,
        output ld_ready, rd_data, rd_valid, rd_err, busy, key_valid
    );
endinterface
`default_nettype wire

// File: rtl/ghash_hkey_bank.sv
`default_nettype none
// ============================================================================
// Module      : ghash_hkey_bank
// Description : NUM_KEYS-slot store for GHASH hash subkeys with per-slot valid
//               bits, valid/ready loading, a registered error-reporting read
//               port and a one-slot-per-cycle zeroize sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module ghash_hkey_bank #(
    parameter int WIDTH    = 128,
    parameter int NUM_KEYS = 4,
    parameter int IDX_W    = 2
) (
    input  wire logic         clk,
    input  wire logic         rst,
    ghash_hkey_bank_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ZERO = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_KEYS - 1);
    localparam logic [IDX_W:0]   c_NUM_KEYS = (IDX_W + 1)'(NUM_KEYS);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    w_cnt_nxt;

    logic [WIDTH-1:0]    w_slots [NUM_KEYS];
    logic [NUM_KEYS-1:0] w_key_valid;

    logic [WIDTH-1:0]    r_rd_data;
    logic                r_rd_valid;
    logic                r_rd_err;

    logic                w_idle;
    logic                w_zero_entry;
    logic                w_ld_fire;
    logic                w_rd_in_range;
    logic                w_rd_hit;
    logic [WIDTH-1:0]    w_rd_slot;
    logic                w_rd_slot_valid;

    // Zeroize has priority over loads: ready drops in the very cycle it is seen.
    assign w_idle       = (r_state == ST_IDLE);
    assign w_zero_entry = w_idle && bus.zeroize;
    assign bus.ld_ready = w_idle && !bus.zeroize;
    assign w_ld_fire    = bus.ld_valid && bus.ld_ready;

    // State and sweep counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: a sweep runs exactly NUM_KEYS cycles and cannot be restarted
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (bus.zeroize) begin
                    w_state_nxt = ST_ZERO;
                    w_cnt_nxt   = '0;
                end
            end
            ST_ZERO: begin
                if (r_cnt == c_LAST_IDX) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // One storage slot per key; out-of-range load indices match no slot.
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_slot
        localparam logic [IDX_W-1:0] c_IDX = IDX_W'(i);

        logic [WIDTH-1:0] r_key;
        logic             r_valid;

        // Slot update: sweep clear, load, and valid-bit drop on zeroize entry
        always_ff @(posedge clk) begin
            if (rst) begin
                r_key   <= '0;
                r_valid <= 1'b0;
            end else begin
                if ((r_state == ST_ZERO) && (r_cnt == c_IDX)) begin
                    r_key <= '0;
                end else if (w_ld_fire && (bus.ld_idx == c_IDX)) begin
                    r_key <= bus.ld_data;
                end

                if (w_zero_entry) begin
                    r_valid <= 1'b0;
                end else if (w_ld_fire && (bus.ld_idx == c_IDX)) begin
                    r_valid <= 1'b1;
                end
            end
        end

        assign w_slots[i]     = r_key;
        assign w_key_valid[i] = r_valid;
    end

    // Read mux over the registered slots (old contents on a same-edge load)
    always_comb begin
        w_rd_slot       = '0;
        w_rd_slot_valid = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (bus.rd_idx == IDX_W'(i)) begin
                w_rd_slot       = w_slots[i];
                w_rd_slot_valid = w_key_valid[i];
            end
        end
    end

    assign w_rd_in_range = ({1'b0, bus.rd_idx} < c_NUM_KEYS);
    assign w_rd_hit      = w_idle && !bus.zeroize && w_rd_in_range && w_rd_slot_valid;

    // Registered read port; any read during or into a sweep reports an error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
        end else begin
            if (bus.rd_en) begin
                r_rd_valid <= 1'b1;
                if (w_rd_hit) begin
                    r_rd_data <= w_rd_slot;
                    r_rd_err  <= 1'b0;
                end else begin
                    r_rd_data <= '0;
                    r_rd_err  <= 1'b1;
                end
            end else begin
                r_rd_valid <= 1'b0;
                r_rd_err   <= 1'b0;
                if (w_zero_entry) begin
                    r_rd_data <= '0;
                end
            end
        end
    end

    assign bus.rd_data   = r_rd_data;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_err    = r_rd_err;
    assign bus.busy      = (r_state == ST_ZERO);
    assign bus.key_valid = w_key_valid;

endmodule
`default_nettype wire

// File: doc/ghash_hkey_bank.md
Name: ghash_hkey_bank

Overview:
Parametrised multi-slot store for GHASH hash subkeys (H). It generalises a single H register into NUM_KEYS independently loadable slots, each with a valid bit. It adds a valid/ready load handshake, a registered read port that reports errors, and a sequential zeroize engine. It sits between the AES key-schedule/H-generation logic and the GHASH multiplier datapath, so several GCM contexts can be held without reloading H.

Parameters:
WIDTH, 128, bit width of each H subkey.
NUM_KEYS, 4, number of key slots (>=2).
IDX_W, 2, slot index width; must equal ceil(log2(NUM_KEYS)).

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
ld_valid  in  1  load request.
ld_ready  out  1  load accept; combinational = (state==IDLE) && !zeroize.
ld_idx  in  IDX_W  target slot for load.
ld_data  in  WIDTH  subkey to store.
rd_en  in  1  read request.
rd_idx  in  IDX_W  slot to read.
rd_data  out  WIDTH  registered read data.
rd_valid  out  1  one-cycle pulse; rd_data/rd_err are valid.
rd_err  out  1  read targeted an invalid or out-of-range slot.
zeroize  in  1  request to clear all slots.
busy  out  1  high while the zeroize sweep runs.
key_valid  out  NUM_KEYS  per-slot valid bits (registered).

Behaviour:
- Reset (rst=1 at an edge): all slots = 0, key_valid = 0, rd_data = 0, rd_valid = 0, rd_err = 0, busy = 0, state = IDLE, sweep counter = 0. Reset overrides everything, including a zeroize sweep in progress.
- States:
  - IDLE: loads and reads are serviced.
  - ZERO: sweep in progress. Entered from IDLE when zeroize=1; returns to IDLE after the clear of slot NUM_KEYS-1.
- Load: on an edge with ld_valid && ld_ready, slot[ld_idx] <= ld_data and key_valid[ld_idx] <= 1.
  - If ld_idx >= NUM_KEYS, the load is accepted but has no effect.
  - Reloading a valid slot overwrites it.
- Read latency is 1 cycle: rd_en sampled at edge N gives rd_valid=1 and rd_data/rd_err after edge N.
  - Valid slot: rd_data = slot contents, rd_err = 0.
  - Invalid slot, out-of-range index, or state ZERO: rd_data = 0, rd_err = 1.
  - rd_en=0 at an edge: rd_valid <= 0, rd_err <= 0, rd_data holds its value.
- Load and read of the same slot at the same edge: the read returns the old contents and old valid status (read-before-write). The new key is readable from the next rd_en onward.
- Zeroize entry (IDLE, zeroize=1, edge E):
  - key_valid <= 0 (all slots), rd_data <= 0, state <= ZERO, busy <= 1, counter <= 0.
  - ld_ready is low in that cycle, so a simultaneous ld_valid is not accepted; zeroize wins.
- ZERO, each edge: slot[counter] <= 0, counter <= counter+1.
  - At the edge that clears slot NUM_KEYS-1: state <= IDLE, busy <= 0, counter <= 0.
  - Sweep length is NUM_KEYS cycles after entry; busy is high for exactly NUM_KEYS cycles.
- zeroize asserted during ZERO is ignored; no restart or extension. ld_ready = 0 throughout ZERO.
- zeroize held high continuously: a new sweep starts in the first IDLE cycle after the previous one finishes.
- No combinational path from ld_data to rd_data.

Test Plan:
- Reset, then load slot 2 with 128'h66E94BD4EF8A2C3B884CFA59CA342B2E; rd_en idx 2 next cycle -> one cycle later rd_valid=1, rd_err=0, rd_data=that value; key_valid=4'b0100.
- Read slot 1 (never loaded) -> rd_valid=1, rd_err=1, rd_data=0; rd_en low next cycle -> rd_valid=0, rd_data stays 0.
- Load slot 0=128'hA5..A5 and read slot 0 at the same edge -> rd_data=0 with rd_err=1; re-read next cycle -> 128'hA5..A5, rd_err=0.
- Load all 4 slots, pulse zeroize together with ld_valid (slot 3, data 128'h1) -> load not accepted, key_valid=0 after that edge, busy high for exactly 4 cycles, ld_ready low throughout; afterwards reading each slot gives rd_err=1, data 0.
- Start zeroize, assert rst after 2 sweep cycles -> next edge: busy=0, state IDLE, all outputs 0, ld_ready=1.
- Out-of-range check with NUM_KEYS=3, IDX_W=2: load idx 3 with data 128'hFF -> key_valid unchanged (3'b000); read idx 3 -> rd_err=1, rd_data=0.
